seq_div_restoring: RTL

Multi-cycle unsigned integer divider for the KGP-miniRISC ALU. It is the inverse companion of the lookahead adder path: it produces one quotient bit per cycle through repeated trial subtraction. The carry-lookahead subtractor sub-block performs each trial subtraction. The block sits beside the ALU and is driven by the control unit through a start/busy/done handshake.

---
 rtl/seq_div_restoring_pkg.sv | 18 +
 rtl/seq_div_restoring_cla_sub.sv | 56 +++++
 rtl/seq_div_restoring.sv | 119 +++++++++++
 3 files changed

// File: rtl/seq_div_restoring_pkg.sv
// Shared definitions for the restoring divider: FSM encoding, default width
// and iteration-counter sizing.
package seq_div_restoring_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_div_restoring_cla_sub.sv
// N-bit subtractor a - b computed as a + ~b + 1 with 4-bit carry-lookahead
// blocks chained through block propagate/generate.
module cla_sub_nbit #(
  parameter int N = 33
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  // Zero padding above bit N-1 leaves the true carry-out visible as c[N].
  localparam int NB = N / 4 + 1;
  localparam int NP = NB * 4;

  logic [NP-1:0] x;
  logic [NP-1:0] y;
  logic [NP-1:0] p;
  logic [NP-1:0] g;
  logic [NP-1:0] c;
  logic [NB:0]   cb;
  logic          unused_hi;

  assign x     = {{(NP-N){1'b0}}, a_i};
  assign y     = {{(NP-N){1'b0}}, ~b_i};
  assign p     = x ^ y;
  assign g     = x & y;
  assign cb[0] = 1'b1;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic [3:0] pk;
    logic [3:0] gk;
    logic       bp;
    logic       bg;

    assign pk = p[4*k +: 4];
    assign gk = g[4*k +: 4];

    assign c[4*k]   = cb[k];
    assign c[4*k+1] = gk[0] | (pk[0] & cb[k]);
    assign c[4*k+2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & cb[k]);
    assign c[4*k+3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
                    | (pk[2] & pk[1] & pk[0] & cb[k]);

    assign bp = &pk;
    assign bg = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1])
              | (pk[3] & pk[2] & pk[1] & gk[0]);

    assign cb[k+1] = bg | (bp & cb[k]);
  end

  assign diff_o   = p[N-1:0] ^ c[N-1:0];
  assign borrow_o = ~c[N];
  assign unused_hi = ^{cb[NB], c[NP-1:N], p[NP-1:N]};

endmodule

// File: rtl/seq_div_restoring.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle via trial
// subtraction, driven through a start/busy/done handshake.
module seq_div_restoring
  import seq_div_restoring_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             div0_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             unused_trial_msb;

  // Trial operand is the shifted {R,Q} upper half, one bit wider than R.
  cla_sub_nbit #(.N(WIDTH + 1)) u_sub (
    .a_i      ({rem_q, quo_q[WIDTH-1]}),
    .b_i      ({1'b0, dvsr_q}),
    .diff_o   (trial),
    .borrow_o (borrow)
  );

  assign unused_trial_msb = trial[WIDTH];

  always_comb begin
    rem_d = trial[WIDTH-1:0];
    quo_d = {quo_q[WIDTH-2:0], ~borrow};
    if (borrow) begin
      rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    end else begin
      rem_d = trial[WIDTH-1:0];
    end
  end

  // For a zero divisor Q still holds the captured dividend when FIN is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      div0_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_q   <= '0;
            quo_q   <= dividend;
            dvsr_q  <= divisor;
            div0_q  <= (divisor == '0);
            dbz_q   <= 1'b0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= (divisor == '0) ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          dbz_q       <= div0_q;
          quotient_q  <= div0_q ? '1 : quo_q;
          remainder_q <= div0_q ? quo_q : rem_q;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
